// File: rtl/pulse_timer_bank.sv
// ============================================================================
// Module   : pulse_timer_bank
// Brief    : NCH independent programmable pulse timers with per-channel
//            periodic/one-shot mode, a one-cycle Pulse and a square-wave Level.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pulse_timer_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 28,
  parameter int CW    = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Wr_En,
  input  logic [CW-1:0]    Wr_Chan,
  input  logic [WIDTH-1:0] Wr_Period,
  input  logic             Wr_Mode,
  input  logic [NCH-1:0]   Start,
  input  logic [NCH-1:0]   Stop,
  output logic [NCH-1:0]   Pulse,
  output logic [NCH-1:0]   Level,
  output logic [NCH-1:0]   Active
);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             active_q, active_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             wr_hit;

    // Out-of-range channel numbers never match any gi, so those writes are dropped.
    assign wr_hit = Wr_En && (Wr_Chan == CW'(gi));

    always_comb begin
      period_d = period_q;
      mode_d   = mode_q;
      count_d  = count_q;
      active_d = active_q;
      pulse_d  = 1'b0;
      level_d  = level_q;

      if (wr_hit) begin
        period_d = Wr_Period;
        mode_d   = Wr_Mode;
        count_d  = '0;
        if (Wr_Period == '0) begin
          active_d = 1'b0;
        end
      end

      // Start checks the post-write period so write+start begins with the new value.
      if (Stop[gi]) begin
        active_d = 1'b0;
        count_d  = '0;
      end else if (Start[gi]) begin
        if (period_d != '0) begin
          active_d = 1'b1;
          count_d  = '0;
        end
      end else if (!wr_hit && active_q) begin
        if (count_q == period_q - WIDTH'(1)) begin
          count_d = '0;
          pulse_d = 1'b1;
          level_d = ~level_q;
          if (mode_q) begin
            active_d = 1'b0;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
    end

    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        period_q <= '0;
        mode_q   <= 1'b0;
        count_q  <= '0;
        active_q <= 1'b0;
        pulse_q  <= 1'b0;
        level_q  <= 1'b0;
      end else begin
        period_q <= period_d;
        mode_q   <= mode_d;
        count_q  <= count_d;
        active_q <= active_d;
        pulse_q  <= pulse_d;
        level_q  <= level_d;
      end
    end

    assign Pulse[gi]  = pulse_q;
    assign Level[gi]  = level_q;
    assign Active[gi] = active_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse_timer_bank.sv
// ============================================================================
// Module   : tb_pulse_timer_bank
// Brief    : Directed self-checking bench for pulse_timer_bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pulse_timer_bank;
  localparam int NCH   = 4;
  localparam int WIDTH = 28;
  localparam int CW    = 3;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Wr_En;
  logic [CW-1:0]    Wr_Chan;
  logic [WIDTH-1:0] Wr_Period;
  logic             Wr_Mode;
  logic [NCH-1:0]   Start;
  logic [NCH-1:0]   Stop;
  logic [NCH-1:0]   Pulse;
  logic [NCH-1:0]   Level;
  logic [NCH-1:0]   Active;

  int checks = 0;
  int errors = 0;

  pulse_timer_bank #(.NCH(NCH), .WIDTH(WIDTH), .CW(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Wr_En(Wr_En), .Wr_Chan(Wr_Chan),
    .Wr_Period(Wr_Period), .Wr_Mode(Wr_Mode), .Start(Start), .Stop(Stop),
    .Pulse(Pulse), .Level(Level), .Active(Active)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_cfg(input int ch, input int per, input logic mode);
    Wr_En = 1'b1; Wr_Chan = CW'(ch); Wr_Period = WIDTH'(per); Wr_Mode = mode;
    step();
    Wr_En = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; Wr_En = 1'b0; Wr_Chan = '0; Wr_Period = '0; Wr_Mode = 1'b0;
    Start = '0; Stop = '0;

    // Reset and start on an unprogrammed channel
    step(); step();
    Reset_n = 1'b1;
    check("rst_pulse", 32'(Pulse), 32'h0);
    check("rst_level", 32'(Level), 32'h0);
    check("rst_active", 32'(Active), 32'h0);
    Start = 4'b0001;
    step();
    Start = '0;
    check("start_p0_active", 32'(Active), 32'h0);
    step();
    check("start_p0_pulse", 32'(Pulse), 32'h0);

    // ch1 periodic P=5: pulses at cycles 6, 11, 16
    write_cfg(1, 5, 1'b0);
    Start = 4'b0010;
    step();
    Start = '0;
    check("ch1_active_c1", 32'(Active), 32'h2);
    for (int c = 2; c <= 16; c++) begin
      logic pe, le;
      step();
      pe = (c == 6) || (c == 11) || (c == 16);
      le = (c >= 6 && c <= 10) || (c >= 16);
      check($sformatf("ch1_pulse_c%0d", c), 32'(Pulse), 32'({2'b00, pe, 1'b0}));
      check($sformatf("ch1_level_c%0d", c), 32'(Level), 32'({2'b00, le, 1'b0}));
    end
    Stop = 4'b0010;
    step();
    Stop = '0;
    check("ch1_stop_active", 32'(Active), 32'h0);
    check("ch1_stop_level", 32'(Level), 32'h2);

    // ch2 one-shot P=3: single pulse at cycle 4
    write_cfg(2, 3, 1'b1);
    Start = 4'b0100;
    step();
    Start = '0;
    for (int c = 2; c <= 24; c++) begin
      step();
      check($sformatf("ch2_pulse_c%0d", c), 32'(Pulse[2]), 32'(c == 4));
      check($sformatf("ch2_active_c%0d", c), 32'(Active[2]), 32'(c < 4));
    end
    check("ch2_level", 32'(Level), 32'h6);

    // ch0 P=1: pulse every cycle from 2, stop at cycle 10
    write_cfg(0, 1, 1'b0);
    Start = 4'b0001;
    step();
    Start = '0;
    check("ch0_pulse_c1", 32'(Pulse[0]), 32'h0);
    for (int c = 2; c <= 10; c++) begin
      step();
      check($sformatf("ch0_pulse_c%0d", c), 32'(Pulse[0]), 32'h1);
      check($sformatf("ch0_level_c%0d", c), 32'(Level[0]), 32'(c % 2 == 0));
    end
    Stop = 4'b0001;
    step();
    Stop = '0;
    for (int c = 11; c <= 13; c++) begin
      check($sformatf("ch0_stop_pulse_c%0d", c), 32'(Pulse[0]), 32'h0);
      check($sformatf("ch0_stop_active_c%0d", c), 32'(Active[0]), 32'h0);
      check($sformatf("ch0_stop_level_c%0d", c), 32'(Level[0]), 32'h1);
      step();
    end

    // ch1 P=5 restarted, rewritten to P=2 while count is 3 (cycle 4)
    Start = 4'b0010;
    step();
    Start = '0;
    step(); step(); step();
    Wr_En = 1'b1; Wr_Chan = 3'd1; Wr_Period = WIDTH'(2); Wr_Mode = 1'b0;
    step();
    Wr_En = 1'b0;
    for (int c = 5; c <= 9; c++) begin
      check($sformatf("ch1_rw_pulse_c%0d", c), 32'(Pulse[1]), 32'((c == 7) || (c == 9)));
      check($sformatf("ch1_rw_level_c%0d", c), 32'(Level[1]), 32'((c < 7) || (c >= 9)));
      step();
    end
    Start = 4'b0010; Stop = 4'b0010;
    step();
    Start = '0; Stop = '0;
    check("startstop_active", 32'(Active), 32'h0);
    step();
    check("startstop_pulse", 32'(Pulse), 32'h0);

    // Out-of-range write must not disable ch0 (P=1) or ch1 (P=2)
    Start = 4'b0011;
    step();
    Start = '0;
    Wr_En = 1'b1; Wr_Chan = 3'd4; Wr_Period = '0; Wr_Mode = 1'b1;
    step();
    Wr_En = 1'b0;
    check("oor_active_c2", 32'(Active), 32'h3);
    check("oor_pulse_c2", 32'(Pulse), 32'h1);
    step();
    check("oor_pulse_c3", 32'(Pulse), 32'h3);
    check("oor_active_c3", 32'(Active), 32'h3);
    Stop = 4'b0011;
    step();
    Stop = '0;

    // ch3 P=8, reset asserted at count 6 (cycle 7)
    write_cfg(3, 8, 1'b0);
    Start = 4'b1000;
    step();
    Start = '0;
    for (int c = 2; c <= 7; c++) step();
    check("ch3_pre_active", 32'(Active), 32'h8);
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    check("ch3_rst_pulse", 32'(Pulse), 32'h0);
    check("ch3_rst_active", 32'(Active), 32'h0);
    check("ch3_rst_level", 32'(Level), 32'h0);
    step();
    check("ch3_post_pulse", 32'(Pulse), 32'h0);
    Start = 4'b1000;
    step();
    Start = '0;
    check("ch3_period_cleared", 32'(Active), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pulse_timer_bank.md
Name: pulse_timer_bank

Overview:
- Bank of NCH independent programmable pulse timers sharing one clock. Each channel has its own period and a periodic or one-shot mode, set through a single channel-addressed write port.
- Each channel emits a one-cycle Pulse strobe at terminal count and a divide-by-2N square-wave Level.
- Successor to the single-channel terminal-count pulse generator. Adds multiple channels, explicit start/stop, one-shot mode, a registered strobe and a square-wave output.
- Feeds game tick, animation and timeout logic.

Parameters:
- NCH, 4, number of timer channels (1..16).
- WIDTH, 28, period/counter width per channel.
- CW, 2, width of channel select; must satisfy 2**CW >= NCH.

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Reset_n  input  1  synchronous active-low reset.
- Wr_En  input  1  config write strobe, one cycle.
- Wr_Chan  input  CW  channel selected by the write.
- Wr_Period  input  WIDTH  new period, in Clk cycles; 0 = channel disabled.
- Wr_Mode  input  1  0 = periodic, 1 = one-shot.
- Start  input  NCH  per-channel start strobe.
- Stop  input  NCH  per-channel stop strobe.
- Pulse  output  NCH  registered one-cycle terminal-count strobe.
- Level  output  NCH  registered square wave, toggles at every terminal count.
- Active  output  NCH  channel is counting.

Behaviour:
- Reset (Reset_n low at a rising Clk edge) clears everything next cycle: Period, Mode, Count, Active, Pulse and Level are all 0 for every channel.
  - Reset overrides every other input in that cycle.
  - Reset asserted mid-count aborts the count with no pulse.
- Per-channel state: Period[WIDTH], Mode, Count[WIDTH], Active, Pulse, Level. All are registers.
- Config write:
  - When Wr_En=1 and Wr_Chan<NCH, that channel loads Period=Wr_Period and Mode=Wr_Mode, and clears Count to 0.
  - Active is unchanged, except that writing Period=0 also clears Active.
  - When Wr_Chan>=NCH the write is ignored.
  - Other channels are unaffected.
- Start[i]=1: next cycle Active[i]=1 and Count[i]=0.
  - Ignored if Period[i]=0, using the Period value after any same-cycle write.
  - Start on an already-active channel restarts it: Count returns to 0, Level is unchanged.
- Stop[i]=1: next cycle Active[i]=0 and Count[i]=0.
  - Stop wins over Start in the same cycle.
  - Level holds its value.
- Start and write to the same channel in the same cycle: the write applies and the channel starts from Count=0 with the new period.
- Counting, while Active[i]=1 and no write/start/stop to channel i:
  - If Count==Period-1: Count←0, Pulse←1, Level←~Level.
  - Otherwise: Count←Count+1, Pulse←0.
- Pulse is 0 in every cycle not directly following a terminal count.
  - Pulse is 0 the cycle after a Stop, Start or write, even if Count was at terminal.
- Latency: with Start at cycle 0, Active=1 from cycle 1 and Count=0 at cycle 1. The first Pulse is at cycle P+1; periodic pulses repeat every P cycles.
- Period=1, periodic: Pulse is high every cycle from cycle 2 onward, and Level toggles every cycle.
- One-shot mode: at terminal count Active←0 on the same edge that Pulse←1. Exactly one pulse per Start.
- Inactive channel: Count holds at 0 and Pulse=0.
- Count arithmetic is unsigned modulo 2**WIDTH. Period-1 never wraps, because Period=0 forbids counting.
- Maximum period is 2**WIDTH-1 cycles.

Test Plan:
- Reset_n low 2 cycles, then high -> Pulse=0, Level=0, Active=0 on all channels; Start[0] alone is ignored because Period=0.
- Write ch1 P=5 periodic, Start[1] at cycle 0 -> Pulse[1] high at cycles 6, 11, 16; Level[1] toggles at each; other channels stay idle.
- Write ch2 P=3 one-shot, Start[2] -> single Pulse[2] at cycle 4, Active[2] falls at cycle 4; no further pulses over 20 cycles.
- Ch0 P=1 periodic -> Pulse[0] high continuously from cycle 2; Stop[0] at cycle 10 -> Pulse[0]=0 and Active[0]=0 from cycle 11.
- Ch1 running P=5, rewrite P=2 at count 3 -> Count clears, next Pulse 2 cycles later; Start+Stop in the same cycle -> channel stopped; write Wr_Chan=NCH -> no state change.
- Ch3 P=8 active, Reset_n low at count 6 -> no pulse, all state cleared next cycle.
